// File: rtl/soc_regwrite_trace_emitter_if.sv
// Register-write trace bundle: dual-lane writeback inputs, single-lane trace outputs
// and FIFO status, shared between the emitter (slave) and its environment (master).
interface soc_regwrite_trace_emitter_if #(
    parameter int DEPTH = 8
);
    logic                     wb0_valid;
    logic                     wb0_we;
    logic [4:0]               wb0_addr;
    logic [31:0]              wb0_data;
    logic                     wb1_valid;
    logic                     wb1_we;
    logic [4:0]               wb1_addr;
    logic [31:0]              wb1_data;
    logic                     valid;
    logic                     we;
    logic [4:0]               addr;
    logic [31:0]              data;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic [15:0]              drop_count;

    modport slave (
        input  wb0_valid, wb0_we, wb0_addr, wb0_data,
        input  wb1_valid, wb1_we, wb1_addr, wb1_data,
        output valid, we, addr, data, level, overflow, drop_count
    );

    modport master (
        output wb0_valid, wb0_we, wb0_addr, wb0_data,
        output wb1_valid, wb1_we, wb1_addr, wb1_data,
        input  valid, we, addr, data, level, overflow, drop_count
    );
endinterface

// File: rtl/soc_regwrite_trace_emitter.sv
// Buffers up to two retirement events per cycle and replays them in program order
// as a single-lane register-write trace; events that do not fit are dropped and counted.
module soc_regwrite_trace_emitter #(
    parameter int DEPTH   = 8,
    parameter bit DROP_X0 = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    soc_regwrite_trace_emitter_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [37:0]   mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   dropCount_q, dropCount_d;

    logic          pop;
    logic          cand0, cand1;
    logic [LW:0]   free;
    logic [1:0]    nCand, nPush, nDrop;
    logic [16:0]   dropSum;
    logic [37:0]   ev0, ev1, firstEv, headEv;

    always_comb begin
        pop     = 1'b0;
        cand0   = 1'b0;
        cand1   = 1'b0;
        free    = '0;
        nCand   = '0;
        nPush   = '0;
        nDrop   = '0;
        dropSum = '0;
        ev0     = {bus.wb0_we, bus.wb0_addr, bus.wb0_data};
        ev1     = {bus.wb1_we, bus.wb1_addr, bus.wb1_data};
        firstEv = ev0;

        pop   = (level_q != '0);
        cand0 = bus.wb0_valid && !(DROP_X0 && bus.wb0_we && (bus.wb0_addr == 5'd0));
        cand1 = bus.wb1_valid && !(DROP_X0 && bus.wb1_we && (bus.wb1_addr == 5'd0));
        // The slot vacated by this cycle's pop is reusable on the same edge.
        free  = (LW+1)'(DEPTH) - {1'b0, level_q} + {{LW{1'b0}}, pop};
        nCand = {1'b0, cand0} + {1'b0, cand1};

        if (free >= (LW+1)'(2))
            nPush = nCand;
        else if (free == (LW+1)'(1))
            nPush = (nCand != 2'd0) ? 2'd1 : 2'd0;
        else
            nPush = 2'd0;

        nDrop   = nCand - nPush;
        firstEv = cand0 ? ev0 : ev1;

        wrPtr_d    = wrPtr_q + PW'(nPush);
        rdPtr_d    = rdPtr_q + PW'(pop);
        level_d    = level_q + LW'(nPush) - LW'(pop);
        overflow_d = overflow_q || (nDrop != 2'd0);
        dropSum    = {1'b0, dropCount_q} + {15'd0, nDrop};
        dropCount_d = dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            dropCount_q <= 16'd0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
        end
    end

    // Storage needs no reset: the output stage masks it whenever level is zero.
    always_ff @(posedge clk) begin
        if (nPush != 2'd0)
            mem_q[wrPtr_q] <= firstEv;
        if (nPush == 2'd2)
            mem_q[wrPtr_q + PW'(1)] <= ev1;
    end

    always_comb begin
        headEv         = mem_q[rdPtr_q];
        bus.valid      = pop;
        bus.we         = pop ? headEv[37] : 1'b0;
        bus.addr       = pop ? headEv[36:32] : 5'd0;
        bus.data       = pop ? headEv[31:0] : 32'd0;
        bus.level      = level_q;
        bus.overflow   = overflow_q;
        bus.drop_count = dropCount_q;
    end
endmodule

// File: tb/tb_soc_regwrite_trace_emitter.sv
// Directed self-checking bench for the register-write trace emitter (DEPTH=8, DROP_X0=1).
module tb_soc_regwrite_trace_emitter;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    logic [31:0] regShadow [32];

    soc_regwrite_trace_emitter_if #(.DEPTH(DEPTH)) bus ();

    soc_regwrite_trace_emitter #(.DEPTH(DEPTH), .DROP_X0(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.valid && bus.we)
            regShadow[bus.addr] <= bus.data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.wb0_valid = 1'b0; bus.wb0_we = 1'b0; bus.wb0_addr = 5'd0; bus.wb0_data = 32'd0;
        bus.wb1_valid = 1'b0; bus.wb1_we = 1'b0; bus.wb1_addr = 5'd0; bus.wb1_data = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        repeat (2) tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            assertCount++;
            if (bus.valid !== 1'b0 || bus.addr !== 5'd0 || bus.data !== 32'd0) begin
                failCount++;
                $display("[TB] FAIL reset_idle_out cyc%0d: got valid=%0b addr=%0d data=%h want 0/0/0", c, bus.valid, bus.addr, bus.data);
            end
            assertCount++;
            if (bus.level !== 4'd0 || bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
                failCount++;
                $display("[TB] FAIL reset_idle_status cyc%0d: got level=%0d ovf=%0b drops=%0d want 0/0/0", c, bus.level, bus.overflow, bus.drop_count);
            end
        end
    endtask

    task automatic test_single_write();
        bus.wb0_valid = 1'b1; bus.wb0_we = 1'b1; bus.wb0_addr = 5'd3; bus.wb0_data = 32'hCAFE0001;
        tick();
        idleInputs();
        assertCount++;
        if (bus.valid !== 1'b1 || bus.we !== 1'b1 || bus.addr !== 5'd3 || bus.data !== 32'hCAFE0001) begin
            failCount++;
            $display("[TB] FAIL single_event: got v=%0b we=%0b addr=%0d data=%h want 1/1/3/cafe0001", bus.valid, bus.we, bus.addr, bus.data);
        end
        assertCount++;
        if (bus.level !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL single_level: got %0d want 1", bus.level);
        end
        tick();
        assertCount++;
        if (bus.valid !== 1'b0 || bus.level !== 4'd0 || bus.data !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL single_drain: got v=%0b level=%0d data=%h want 0/0/0", bus.valid, bus.level, bus.data);
        end
        assertCount++;
        if (regShadow[3] !== 32'hCAFE0001) begin
            failCount++;
            $display("[TB] FAIL single_shadow_r3: got %h want cafe0001", regShadow[3]);
        end
    endtask

    task automatic test_dual_burst();
        bus.wb0_valid = 1'b1; bus.wb0_we = 1'b1; bus.wb0_addr = 5'd5; bus.wb0_data = 32'd1;
        bus.wb1_valid = 1'b1; bus.wb1_we = 1'b1; bus.wb1_addr = 5'd3; bus.wb1_data = 32'd2;
        tick();
        idleInputs();
        assertCount++;
        if (bus.valid !== 1'b1 || bus.addr !== 5'd5 || bus.data !== 32'd1 || bus.level !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL dual_first: got v=%0b addr=%0d data=%0d level=%0d want 1/5/1/2", bus.valid, bus.addr, bus.data, bus.level);
        end
        tick();
        assertCount++;
        if (bus.valid !== 1'b1 || bus.addr !== 5'd3 || bus.data !== 32'd2 || bus.level !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL dual_second: got v=%0b addr=%0d data=%0d level=%0d want 1/3/2/1", bus.valid, bus.addr, bus.data, bus.level);
        end
        tick();
        assertCount++;
        if (bus.valid !== 1'b0 || bus.level !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL dual_drain: got v=%0b level=%0d want 0/0", bus.valid, bus.level);
        end
    endtask

    task automatic test_x0_filter();
        bus.wb0_valid = 1'b1; bus.wb0_we = 1'b1; bus.wb0_addr = 5'd0; bus.wb0_data = 32'h99;
        bus.wb1_valid = 1'b1; bus.wb1_we = 1'b0; bus.wb1_addr = 5'd0; bus.wb1_data = 32'd7;
        tick();
        idleInputs();
        assertCount++;
        if (bus.valid !== 1'b1 || bus.we !== 1'b0 || bus.addr !== 5'd0 || bus.data !== 32'd7 || bus.level !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL x0_event: got v=%0b we=%0b addr=%0d data=%0d level=%0d want 1/0/0/7/1", bus.valid, bus.we, bus.addr, bus.data, bus.level);
        end
        tick();
        assertCount++;
        if (bus.valid !== 1'b0 || bus.drop_count !== 16'd0 || bus.overflow !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL x0_after: got v=%0b drops=%0d ovf=%0b want 0/0/0", bus.valid, bus.drop_count, bus.overflow);
        end
    endtask

    task automatic test_lane1_only();
        bus.wb1_valid = 1'b1; bus.wb1_we = 1'b1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h55;
        tick();
        idleInputs();
        assertCount++;
        if (bus.valid !== 1'b1 || bus.addr !== 5'd9 || bus.data !== 32'h55 || bus.level !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL lane1_only: got v=%0b addr=%0d data=%h level=%0d want 1/9/55/1", bus.valid, bus.addr, bus.data, bus.level);
        end
        tick();
        assertCount++;
        if (bus.valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL lane1_drain: got v=%0b want 0", bus.valid);
        end
    endtask

    task automatic test_overflow();
        logic [37:0] expQ [$];
        logic [37:0] ev [2];
        int          expDrops;
        int          free;
        bit          pop;
        expDrops = 0;
        for (int k = 0; k < 10; k++) begin
            ev[0] = {1'b1, 5'(2 * k % 31 + 1), 32'h1000_0000 + 32'(2 * k)};
            ev[1] = {1'b1, 5'((2 * k + 1) % 31 + 1), 32'h1000_0000 + 32'(2 * k + 1)};
            bus.wb0_valid = 1'b1; bus.wb0_we = ev[0][37]; bus.wb0_addr = ev[0][36:32]; bus.wb0_data = ev[0][31:0];
            bus.wb1_valid = 1'b1; bus.wb1_we = ev[1][37]; bus.wb1_addr = ev[1][36:32]; bus.wb1_data = ev[1][31:0];
            pop  = (expQ.size() != 0);
            free = DEPTH - expQ.size() + (pop ? 1 : 0);
            if (pop) void'(expQ.pop_front());
            for (int l = 0; l < 2; l++) begin
                if (free > 0) begin
                    expQ.push_back(ev[l]);
                    free--;
                end else begin
                    expDrops++;
                end
            end
            tick();
            assertCount++;
            if (bus.level !== 4'(expQ.size()) || bus.valid !== 1'b1 || {bus.we, bus.addr, bus.data} !== expQ[0]) begin
                failCount++;
                $display("[TB] FAIL ovf_fill cyc%0d: got level=%0d ev=%h want level=%0d ev=%h", k, bus.level, {bus.we, bus.addr, bus.data}, expQ.size(), expQ[0]);
            end
        end
        idleInputs();
        assertCount++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 16'(expDrops) || expDrops != 3) begin
            failCount++;
            $display("[TB] FAIL ovf_drops: got ovf=%0b drops=%0d want 1/%0d (model drops expected 3)", bus.overflow, bus.drop_count, expDrops);
        end
        for (int n = 0; n < 2 * DEPTH && expQ.size() != 0; n++) begin
            void'(expQ.pop_front());
            tick();
            assertCount++;
            if (bus.level !== 4'(expQ.size()) || (expQ.size() != 0 && {bus.we, bus.addr, bus.data} !== expQ[0])) begin
                failCount++;
                $display("[TB] FAIL ovf_drain step%0d: got level=%0d ev=%h want level=%0d", n, bus.level, {bus.we, bus.addr, bus.data}, expQ.size());
            end
        end
        assertCount++;
        if (bus.valid !== 1'b0 || bus.overflow !== 1'b1 || bus.drop_count !== 16'd3) begin
            failCount++;
            $display("[TB] FAIL ovf_final: got v=%0b ovf=%0b drops=%0d want 0/1/3", bus.valid, bus.overflow, bus.drop_count);
        end
    endtask

    task automatic test_async_reset();
        bus.wb0_valid = 1'b1; bus.wb0_we = 1'b1; bus.wb0_addr = 5'd11; bus.wb0_data = 32'hDEAD0000;
        bus.wb1_valid = 1'b1; bus.wb1_we = 1'b1; bus.wb1_addr = 5'd12; bus.wb1_data = 32'hDEAD0001;
        repeat (3) tick();
        idleInputs();
        assertCount++;
        if (bus.level !== 4'd4) begin
            failCount++;
            $display("[TB] FAIL arst_pre_level: got %0d want 4", bus.level);
        end
        #2;
        rst = 1'b1;
        #1;
        assertCount++;
        if (bus.valid !== 1'b0 || bus.level !== 4'd0 || bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL arst_immediate: got v=%0b level=%0d ovf=%0b drops=%0d want 0/0/0/0", bus.valid, bus.level, bus.overflow, bus.drop_count);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            assertCount++;
            if (bus.valid !== 1'b0 || bus.level !== 4'd0) begin
                failCount++;
                $display("[TB] FAIL arst_stale cyc%0d: got v=%0b level=%0d want 0/0", c, bus.valid, bus.level);
            end
        end
        bus.wb0_valid = 1'b1; bus.wb0_we = 1'b1; bus.wb0_addr = 5'd7; bus.wb0_data = 32'hABCD;
        tick();
        idleInputs();
        assertCount++;
        if (bus.valid !== 1'b1 || bus.addr !== 5'd7 || bus.data !== 32'hABCD || bus.level !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL arst_fresh: got v=%0b addr=%0d data=%h level=%0d want 1/7/abcd/1", bus.valid, bus.addr, bus.data, bus.level);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        for (int r = 0; r < 32; r++) regShadow[r] = 32'd0;
        test_reset();
        test_single_write();
        test_dual_burst();
        test_x0_filter();
        test_lane1_only();
        test_overflow();
        test_async_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
